deco_estado_seq: RTL and testbench
==================================

# deco_estado_seq

Parametrised state sequencer with threshold decoding. Holds a W-bit state index that steps modulo N_ESTADOS on qualified advance requests. Decodes the index against a run-time-loadable threshold into a registered level OUT, with one-cycle rise, fall and wrap pulses. Sits between the control FSM and the datapath enables, replacing fixed-table state decoders.

## Interface
Parameters:
- W, 3: state index width.
- N_ESTADOS, 6: number of states, 2..2^W; index runs 0..N_ESTADOS-1.
- UMBRAL_RST, 3: threshold after reset, 0..N_ESTADOS.
- DWELL, 4: minimum cycles per state, ≥1; only used with DECO_ESTADO_DWELL_EN.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous reset, active low.
- EN  in  1  global enable; when 0, ADV is ignored.
- ADV  in  1  advance request, sampled each edge.
- CLR  in  1  synchronous return to state 0.
- LOAD_UMBRAL  in  1  load threshold from UMBRAL_IN.
- UMBRAL_IN  in  W+1  new threshold value.
- ESTADO  out  W  current state index.
- OUT  out  1  registered decode: 1 when ESTADO ≥ threshold.
- SUBE  out  1  one-cycle pulse when OUT goes 0→1.
- BAJA  out  1  one-cycle pulse when OUT goes 1→0.
- WRAP  out  1  one-cycle pulse when the index wraps N_ESTADOS-1→0 through ADV.
- LISTO  out  1  ADV will be accepted at the next edge (dwell satisfied).

## Operation
- Reset (RST_N=0, asynchronous):
  - ESTADO=0.
  - Threshold register=UMBRAL_RST.
  - OUT=(UMBRAL_RST==0).
  - SUBE=BAJA=WRAP=0.
  - Dwell counter=0; LISTO=1.
- Per-edge priority is CLR > accepted ADV > hold.
  - CLR: ESTADO←0 regardless of EN, ADV or dwell. No WRAP.
  - Accepted ADV requires EN=1, ADV=1 and LISTO=1. It sets ESTADO←(ESTADO==N_ESTADOS-1)?0:ESTADO+1. On wrap, WRAP=1 for exactly the following cycle.
- Threshold register:
  - LOAD_UMBRAL=1 loads UMBRAL_IN at the edge.
  - Values > N_ESTADOS clamp to N_ESTADOS, which makes OUT constantly 0.
  - Value 0 makes OUT constantly 1.
- OUT is computed from the next ESTADO and the next threshold at the same edge. OUT therefore always matches the currently visible ESTADO and threshold, with no extra cycle of lag.
  - This holds for simultaneous LOAD_UMBRAL + ADV and for LOAD_UMBRAL + CLR.
- SUBE/BAJA are derived from the OUT transition at the edge and are high for one cycle only. They can never both be 1. Neither fires at reset release.
- Arithmetic: the comparison is unsigned, W+1 bits. The index never reaches values ≥ N_ESTADOS.

## Timing
- ESTADO, OUT, SUBE, BAJA, WRAP and LISTO are all registered; none is combinational from inputs.
- Latency:
  - ADV sampled at edge k → ESTADO/OUT updated after edge k.
  - SUBE/BAJA/WRAP are valid in cycle k+1 only.
- ADV is a level: held high with dwell disabled, the state advances every cycle.
- Reset asserted mid-sequence clears all outputs immediately. The first edge after release behaves as a normal edge with LISTO=1.

## Configuration
- DECO_ESTADO_DWELL_EN defined:
  - Any change of ESTADO (ADV or CLR that changes the value) loads the dwell counter with DWELL-1.
  - The counter decrements to 0 and saturates there.
  - LISTO=(counter==0).
  - An ADV sampled while LISTO=0 is dropped, not queued.
  - ESTADO therefore holds ≥DWELL cycles. With DWELL=1, LISTO is always 1.
  - CLR in state 0 does not reload the counter.
- DECO_ESTADO_DWELL_EN undefined: no counter is built, LISTO is tied to 1, and DWELL is ignored.

## Test plan
- Reset with defaults → ESTADO=0, OUT=0, LISTO=1. Then ADV=EN=1 continuously, dwell off → ESTADO 1,2,3,4,5,0. SUBE when entering 3, BAJA and WRAP when entering 0.
- Hold ESTADO=4 (OUT=1), LOAD_UMBRAL with UMBRAL_IN=5 → OUT=0 and BAJA=1 in the next cycle. Load 0 → OUT=1 and SUBE=1. Load 9 → threshold clamps to 6 and OUT=0.
- ESTADO=2 with threshold 3: ADV and LOAD_UMBRAL(2) in the same cycle → ESTADO=3, OUT=1, a single SUBE pulse.
- ESTADO=5, CLR and ADV in the same cycle → ESTADO=0, WRAP=0, BAJA=1.
- Dwell on, DWELL=4, ADV held high from reset → ESTADO changes every 4 cycles. LISTO is low for 3 cycles after each change. Pulsing ADV while LISTO=0 has no effect.
- Assert RST_N=0 mid-cycle at ESTADO=4 → all outputs return to reset values without waiting for a CLK edge. Then EN=0 with ADV=1 → ESTADO stays 0.

Source files
------------

// File: rtl/deco_estado_seq.sv
// State index sequencer (modulo N_ESTADOS) with a run-time threshold decode and edge pulses.
// Optional minimum-dwell gating on ADV is built only when DECO_ESTADO_DWELL_EN is defined.
module deco_estado_seq #(
  parameter int W          = 3,
  parameter int N_ESTADOS  = 6,
  parameter int UMBRAL_RST = 3,
  parameter int DWELL      = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic         adv_i,
  input  logic         clr_i,
  input  logic         load_umbral_i,
  input  logic [W:0]   umbral_in_i,
  output logic [W-1:0] estado_o,
  output logic         out_o,
  output logic         sube_o,
  output logic         baja_o,
  output logic         wrap_o,
  output logic         listo_o
);

  localparam logic [W-1:0] ULTIMO = W'(N_ESTADOS - 1);
  localparam logic [W:0]   UMAX   = (W+1)'(N_ESTADOS);
  localparam logic [W:0]   URST   = (W+1)'(UMBRAL_RST);

  logic [W-1:0] estado_q, estado_d;
  logic [W:0]   umbral_q, umbral_d;
  logic         out_q, out_d;
  logic         sube_q, sube_d;
  logic         baja_q, baja_d;
  logic         wrap_q, wrap_d;
  logic         listo;
  logic         adv_ok;

  always_comb begin
    umbral_d = umbral_q;
    estado_d = estado_q;
    wrap_d   = 1'b0;
    adv_ok   = en_i & adv_i & listo;
    if (load_umbral_i)
      umbral_d = (umbral_in_i > UMAX) ? UMAX : umbral_in_i;
    if (clr_i) begin
      estado_d = '0;
    end else if (adv_ok) begin
      if (estado_q == ULTIMO) begin
        estado_d = '0;
        wrap_d   = 1'b1;
      end else begin
        estado_d = estado_q + 1'b1;
      end
    end
    // Decode from next-state values so OUT never lags ESTADO or the threshold.
    out_d  = ({1'b0, estado_d} >= umbral_d);
    sube_d = out_d & ~out_q;
    baja_d = ~out_d & out_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      estado_q <= '0;
      umbral_q <= URST;
      out_q    <= (URST == '0);
      sube_q   <= 1'b0;
      baja_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      umbral_q <= umbral_d;
      out_q    <= out_d;
      sube_q   <= sube_d;
      baja_q   <= baja_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef DECO_ESTADO_DWELL_EN
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CARGA = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (estado_d != estado_q)
      cnt_d = CARGA;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign listo = (cnt_q == '0);
`else
  // DWELL >= 1 is a legal-parameter requirement, so this is constant 1.
  assign listo = (DWELL >= 1);
`endif

  assign estado_o = estado_q;
  assign out_o    = out_q;
  assign sube_o   = sube_q;
  assign baja_o   = baja_q;
  assign wrap_o   = wrap_q;
  assign listo_o  = listo;

endmodule

// File: tb/tb_deco_estado_seq.sv
// Directed + random bench for deco_estado_seq against a cycle-level behavioural model.
module tb_deco_estado_seq;
  localparam int W          = 3;
  localparam int N_ESTADOS  = 6;
  localparam int UMBRAL_RST = 3;
  localparam int DWELL      = 4;
`ifdef DECO_ESTADO_DWELL_EN
  localparam bit DWELL_ON = 1'b1;
`else
  localparam bit DWELL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, adv, clr, ld;
  logic [W:0]   uin;
  logic [W-1:0] estado;
  logic         out, sube, baja, wrap, listo;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_est, m_thr, m_cnt;
  bit m_out, m_sube, m_baja, m_wrap;

  always #5 clk = ~clk;

  deco_estado_seq #(.W(W), .N_ESTADOS(N_ESTADOS), .UMBRAL_RST(UMBRAL_RST), .DWELL(DWELL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .adv_i(adv), .clr_i(clr),
    .load_umbral_i(ld), .umbral_in_i(uin), .estado_o(estado), .out_o(out),
    .sube_o(sube), .baja_o(baja), .wrap_o(wrap), .listo_o(listo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_listo();
    return !DWELL_ON || (m_cnt == 0);
  endfunction

  task automatic model_reset();
    m_est = 0; m_thr = UMBRAL_RST; m_cnt = 0;
    m_out = (UMBRAL_RST == 0); m_sube = 0; m_baja = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit e, input bit a, input bit c, input bit l, input int v);
    bit acc, nout;
    int nest;
    acc  = e && a && m_listo() && !c;
    nest = c ? 0 : (acc ? (m_est + 1) % N_ESTADOS : m_est);
    if (l) m_thr = (v > N_ESTADOS) ? N_ESTADOS : v;
    nout   = (nest >= m_thr);
    m_sube = nout && !m_out;
    m_baja = !nout && m_out;
    m_wrap = acc && (m_est == N_ESTADOS - 1);
    if (nest != m_est) m_cnt = DWELL - 1;
    else if (m_cnt > 0) m_cnt--;
    m_est = nest;
    m_out = nout;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".estado"}, 32'(estado), 32'(m_est));
    chk({tag, ".out"},    32'(out),    32'(m_out));
    chk({tag, ".sube"},   32'(sube),   32'(m_sube));
    chk({tag, ".baja"},   32'(baja),   32'(m_baja));
    chk({tag, ".wrap"},   32'(wrap),   32'(m_wrap));
    chk({tag, ".listo"},  32'(listo),  32'(m_listo()));
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input string tag, input bit e, input bit a, input bit c, input bit l, input int v);
    en = e; adv = a; clr = c; ld = l; uin = (W+1)'(v);
    @(posedge clk);
    model_edge(e, a, c, l, v);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic goto_est(input int tgt);
    for (int g = 0; g < 64 && m_est != tgt; g++) step("goto", 1, 1, 0, 0, 0);
  endtask

  task automatic settle();
    for (int g = 0; g < 16 && !m_listo(); g++) step("settle", 1, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 0; adv = 0; clr = 0; ld = 0; uin = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst.estado", 32'(estado), 32'd0);
    chk("rst.out",    32'(out),    32'd0);
    chk("rst.listo",  32'(listo),  32'd1);
    chk("rst.pulses", 32'({sube, baja, wrap}), 32'd0);
    rst_n = 1'b1;

    // continuous advance through a full lap
    for (int i = 0; i < 6 * DWELL; i++) step("run", 1, 1, 0, 0, 0);

    // threshold loads while holding state 4
    goto_est(4);
    step("ld5", 1, 0, 0, 1, 5);
    chk("ld5.out",  32'(out),  32'd0);
    chk("ld5.baja", 32'(baja), 32'd1);
    step("ld0", 1, 0, 0, 1, 0);
    chk("ld0.out",  32'(out),  32'd1);
    chk("ld0.sube", 32'(sube), 32'd1);
    step("ld9", 1, 0, 0, 1, 9);
    chk("ld9.out",  32'(out),  32'd0);
    settle();
    goto_est(5);
    chk("clamp.out", 32'(out), 32'd0);

    // simultaneous ADV + LOAD at state 2, threshold 3
    step("ld3", 1, 0, 0, 1, 3);
    goto_est(2);
    settle();
    step("advld", 1, 1, 0, 1, 2);
    chk("advld.estado", 32'(estado), 32'd3);
    chk("advld.out",    32'(out),    32'd1);
    chk("advld.sube",   32'(sube),   32'd1);
    step("advld.hold", 1, 0, 0, 0, 0);
    chk("advld.sube1", 32'(sube), 32'd0);

    // CLR beats ADV at the wrap point
    goto_est(5);
    settle();
    step("clradv", 1, 1, 1, 0, 0);
    chk("clradv.estado", 32'(estado), 32'd0);
    chk("clradv.wrap",   32'(wrap),   32'd0);
    chk("clradv.baja",   32'(baja),   32'd1);
    step("clr0", 1, 0, 1, 0, 0);

    // ADV pulses, some landing while dwell is pending
    for (int i = 0; i < 16; i++) step("pulse", 1, i[0], 0, 0, 0);

    // asynchronous reset mid-cycle at state 4
    goto_est(4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.estado", 32'(estado), 32'd0);
    chk("arst.out",    32'(out),    32'd0);
    chk("arst.pulses", 32'({sube, baja, wrap}), 32'd0);
    chk("arst.listo",  32'(listo),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("en0", 0, 1, 0, 0, 0);
    chk("en0.estado", 32'(estado), 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step("rnd", $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 2**(W+1) - 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
